// File: rtl/mod_wrap_counter.sv
`default_nettype none
// ============================================================================
//  Module      : mod_wrap_counter
//  Description : WIDTH-generic modulo up/down counter over [0, max] with
//                wrap-around at either end, clamped synchronous load, and a
//                one-cycle registered wrap pulse. at_max is combinational.
//                Define MOD_WRAP_COUNTER_PRESCALE_EN to add a prescaler so
//                that a count step happens only once every PRESCALE enabled
//                edges.
//  Revision    : 1.0 - initial release
// ============================================================================
module mod_wrap_counter #(
  parameter int WIDTH    = 5,
  parameter int PRESCALE = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             en,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic [WIDTH-1:0] max,
  output logic [WIDTH-1:0] count,
  output logic             wrap,
  output logic             at_max
);

  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] ZERO = '0;

  // Qualified "take a count step on this edge" strobe.
  logic step;

`ifdef MOD_WRAP_COUNTER_PRESCALE_EN
  // Prescaler is at least one bit wide so PRESCALE=1 still elaborates.
  localparam int              PW         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]   PRESC_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] presc;
  logic          presc_terminal;

  assign presc_terminal = (presc == PRESC_LAST);
  assign step           = en && !load && presc_terminal;

  // Prescaler: cleared by load, frozen while en is low, wraps at PRESCALE-1.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      presc <= '0;
    end else if (load) begin
      presc <= '0;
    end else if (en) begin
      if (presc_terminal) begin
        presc <= '0;
      end else begin
        presc <= presc + PW'(1);
      end
    end
  end
`else
  // Without the prescaler every enabled, non-load edge is a step.
  logic unused_prescale;
  assign unused_prescale = (PRESCALE > 0);
  assign step            = en && !load;
`endif

  logic [WIDTH-1:0] count_next;
  logic             wrap_next;
  logic [WIDTH-1:0] load_clamped;

  assign load_clamped = (load_value > max) ? max : load_value;

  // Next-state rules: load beats step, step beats hold. Out-of-range counts
  // (max lowered below count) resolve to the wrap target on the next step.
  always_comb begin
    count_next = count;
    wrap_next  = 1'b0;
    if (load) begin
      count_next = load_clamped;
      wrap_next  = 1'b0;
    end else if (step) begin
      if (!dir) begin
        if (count >= max) begin
          count_next = ZERO;
          wrap_next  = 1'b1;
        end else begin
          count_next = count + ONE;
        end
      end else begin
        if ((count == ZERO) || (count > max)) begin
          count_next = max;
          wrap_next  = 1'b1;
        end else begin
          count_next = count - ONE;
        end
      end
    end
  end

  // Count and wrap-pulse registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
      wrap  <= 1'b0;
    end else begin
      count <= count_next;
      wrap  <= wrap_next;
    end
  end

  assign at_max = (count == max);

endmodule
`default_nettype wire

// File: tb/tb_mod_wrap_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mod_wrap_counter
//  Description : Self-checking bench for mod_wrap_counter (WIDTH=5,
//                PRESCALE=4). Directed scenarios followed by random cycles,
//                all compared against an arithmetic reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mod_wrap_counter;

  localparam int WIDTH    = 5;
  localparam int PRESCALE = 4;
`ifdef MOD_WRAP_COUNTER_PRESCALE_EN
  localparam int PS = PRESCALE;
`else
  localparam int PS = 1;
`endif

  logic             clock = 1'b0;
  logic             reset_n = 1'b0;
  logic             en = 1'b0;
  logic             dir = 1'b0;
  logic             load = 1'b0;
  logic [WIDTH-1:0] load_value = '0;
  logic [WIDTH-1:0] max = '0;
  logic [WIDTH-1:0] count;
  logic             wrap;
  logic             at_max;

  mod_wrap_counter #(.WIDTH(WIDTH), .PRESCALE(PRESCALE)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .en         (en),
    .dir        (dir),
    .load       (load),
    .load_value (load_value),
    .max        (max),
    .count      (count),
    .wrap       (wrap),
    .at_max     (at_max)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state, plain integers.
  int m_count = 0;
  int m_wrap  = 0;
  int m_presc = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // Apply one edge of the spec's rules to the model.
  task automatic model_edge();
    int mx, do_step;
    mx = int'(max);
    do_step = 0;
    if (load) begin
      m_count = (int'(load_value) < mx) ? int'(load_value) : mx;
      m_wrap  = 0;
      m_presc = 0;
    end else begin
      if (en) begin
        if (m_presc == PS - 1) begin
          do_step = 1;
          m_presc = 0;
        end else begin
          m_presc = m_presc + 1;
        end
      end
      m_wrap = 0;
      if (do_step) begin
        if (!dir) begin
          if (m_count >= mx) begin m_count = 0; m_wrap = 1; end
          else m_count = m_count + 1;
        end else begin
          if (m_count == 0 || m_count > mx) begin m_count = mx; m_wrap = 1; end
          else m_count = m_count - 1;
        end
      end
    end
  endtask

  // Drive inputs, let one edge pass, then check all outputs.
  task automatic cyc(input logic e, input logic d, input logic l,
                     input int lv, input int mx, input string tag);
    en = e; dir = d; load = l;
    load_value = WIDTH'(lv); max = WIDTH'(mx);
    model_edge();
    @(posedge clock); #1;
    check({tag, ".count"},  int'(count),  m_count);
    check({tag, ".wrap"},   int'(wrap),   m_wrap);
    check({tag, ".at_max"}, int'(at_max), (m_count == int'(max)) ? 1 : 0);
  endtask

  // Async reset between edges; outputs must clear before the next edge.
  task automatic async_reset(input string tag);
    reset_n = 1'b0;
    #2;
    check({tag, ".rst_count"},  int'(count),  0);
    check({tag, ".rst_wrap"},   int'(wrap),   0);
    check({tag, ".rst_at_max"}, int'(at_max), (max == '0) ? 1 : 0);
    m_count = 0; m_wrap = 0; m_presc = 0;
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    // Reset state.
    max = 5'd3;
    #2;
    check("reset.count", int'(count), 0);
    check("reset.wrap",  int'(wrap),  0);
    check("reset.at_max", int'(at_max), 0);
    @(posedge clock); #1;
    reset_n = 1'b1;

    // Up-wrap with max=3.
    for (int i = 0; i < 6 * PS; i++) cyc(1, 0, 0, 0, 3, "upwrap");

    // Down-wrap with a direction change, max=4.
    cyc(0, 0, 1, 1, 4, "dw.load");
    for (int i = 0; i < 3 * PS; i++) cyc(1, 1, 0, 0, 4, "dw.down");
    for (int i = 0; i < PS; i++) cyc(1, 0, 0, 0, 4, "dw.up");

    // Load priority and clamp.
    cyc(1, 1, 1, 9, 6, "load.clamp");
    check("load.clamp_const", int'(count), 6);
    cyc(1, 0, 1, 2, 6, "load.plain");
    check("load.plain_const", int'(count), 2);

    // Shrinking max, up then down.
    cyc(0, 0, 1, 7, 15, "shrink.load");
    cyc(0, 0, 0, 0, 3, "shrink.hold");
    check("shrink.hold_const", int'(count), 7);
    for (int i = 0; i < PS; i++) cyc(1, 0, 0, 0, 3, "shrink.up");
    cyc(0, 0, 1, 7, 15, "shrink.load2");
    cyc(0, 1, 0, 0, 3, "shrink.hold2");
    for (int i = 0; i < PS; i++) cyc(1, 1, 0, 0, 3, "shrink.down");

    // Async reset mid-run at count=5, then full-width wrap.
    cyc(0, 0, 1, 5, 10, "ar.load");
    async_reset("ar");
    cyc(0, 0, 1, 29, 31, "full.load");
    for (int i = 0; i < 4 * PS; i++) cyc(1, 0, 0, 0, 31, "full.up");

    // max=0: every step wraps to 0.
    for (int i = 0; i < 3 * PS; i++) cyc(1, i[0], 0, 0, 0, "max0");

    // Prescale period with en gaps and a mid-period load.
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 20, "ps.run");
    cyc(0, 0, 0, 0, 20, "ps.gap"); cyc(0, 0, 0, 0, 20, "ps.gap");
    for (int i = 0; i < 6; i++) cyc(1, 0, 0, 0, 20, "ps.resume");
    cyc(1, 0, 1, 10, 20, "ps.load");
    for (int i = 0; i < 5; i++) cyc(1, 0, 0, 0, 20, "ps.afterload");

    // Randomized run.
    begin
      int mx;
      mx = 7;
      for (int i = 0; i < 600; i++) begin
        if ($urandom_range(0, 15) == 0) begin
          case ($urandom_range(0, 3))
            0: mx = 0;
            1: mx = 31;
            default: mx = int'($urandom_range(0, 31));
          endcase
        end
        if ($urandom_range(0, 149) == 0) async_reset("rnd");
        cyc(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0,
            1'($urandom_range(0, 1)),
            ($urandom_range(0, 11) == 0) ? 1'b1 : 1'b0,
            int'($urandom_range(0, 31)), mx, "rnd");
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
